hc595_chain: RTL
================

# hc595_chain

Parametrised serial driver for a daisy-chain of CHIPS 74HC595 shift registers. It accepts a parallel word of 8·CHIPS bits through a valid/ready handshake and shifts it out on ds/shcp, MSB-first or LSB-first. It then pulses stcp once to latch all chips together and reports completion with a one-cycle done pulse. It sits between display/LED control logic and the board's 595 chain, replacing the fixed 16-bit single-shot driver with a configurable, back-pressured one.

## Interface
- CHIPS, 2: number of chained 74HC595 devices. Frame width W = 8·CHIPS. Legal range 1..16.
- DIV, 4: length of each shcp phase (low or high) in clk cycles. Legal range ≥1.
- MSB_FIRST, 1: 1 shifts din[W-1] first; 0 shifts din[0] first.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  W  frame to shift out; sampled only on accept.
- din_vld  input  1  frame valid.
- din_rdy  output  1  high when in IDLE; accept = din_vld && din_rdy.
- shcp  output  1  shift clock to the chain.
- stcp  output  1  storage-register latch clock to the chain.
- ds  output  1  serial data to the first chip.
- busy  output  1  high in SHIFT or LATCH.
- done  output  1  one-cycle pulse when a frame has been latched.

## Operation
- Reset values: shcp=0, stcp=0, ds=0, busy=0, done=0, din_rdy=1. State goes to IDLE and all counters clear.
- FSM has three states: IDLE, SHIFT, LATCH.
- IDLE: on accept, load din into the shift register, clear the bit counter and phase counter, and go to SHIFT. Present the first bit on ds on the same edge.
- SHIFT: each bit has DIV cycles with shcp=0 followed by DIV cycles with shcp=1.
  - ds changes only on the edge where shcp goes 1→0, so it is stable for the full high phase.
  - After the high phase of bit W-1, shcp returns to 0 and the FSM goes to LATCH.
- LATCH: stcp=1 for DIV cycles, then stcp=0, done=1 for one cycle, and the FSM returns to IDLE.
- The bit counter is ceil(log2(W)) bits wide and the phase counter is ceil(log2(DIV)) bits wide (minimum 1). Neither counter wraps mid-frame.
- din_vld while busy is ignored; no frame is queued and din is not resampled.
- rst asserted mid-frame: all outputs and state return to reset values on the next edge. stcp is never pulsed for the aborted frame, so the chips' outputs keep the previous frame.
- After a frame, ds holds the last shifted bit until the next accept.

## Timing
- Cycle numbers are counted from the accept edge (cycle 0).
- Bit k (0-based) is presented on ds from cycle 1+2·DIV·k.
- The shcp rising edge for bit k falls at cycle 1+2·DIV·k+DIV.
- stcp rises at cycle 1+2·DIV·W and is high for exactly DIV cycles.
- done and din_rdy are high at cycle T = 1+2·DIV·W+DIV.
- A new accept is possible at T, so back-to-back frames have period T clk cycles.
- stcp and shcp are never high in the same cycle.
- busy is the inverse of din_rdy at all times.

## Configuration
- HC595_OE_EN defined: adds output port oe_n (1 bit, reset 1) for the chain's /OE pin.
  - oe_n stays 1 after reset until the first completed LATCH.
  - It goes to 0 in the cycle done pulses and stays 0 until the next rst.
  - This prevents random power-up register contents from being displayed.
- HC595_OE_EN undefined: there is no oe_n port. The board ties /OE low externally, and all other behaviour is identical.

## Test plan
- Reset: hold rst 3 cycles mid-idle → shcp=stcp=ds=busy=done=0 and din_rdy=1. Then accept 16'hFFFF, assert rst at cycle 10 → no stcp pulse, outputs at reset values next cycle.
- Single frame, CHIPS=2, DIV=2, MSB_FIRST=1, din=16'hA55A → 16 shcp rises at cycles 3,7,…,63. ds sampled there = 1010_0101_0101_1010. stcp high cycles 65–66. done=1 only at cycle 67.
- LSB-first, MSB_FIRST=0, din=16'h0001 → ds=1 at the first shcp rise and 0 at the remaining 15.
- Back-to-back, din_vld held high with 16'h1234 then 16'hABCD → second accept at cycle 67. Two stcp pulses 67 cycles apart, and ds streams match each word.
- Busy-ignore: during frame 16'h00FF, pulse din_vld with 16'hFFFF at cycle 20 → shifted data stays 16'h00FF and exactly one done pulse occurs.
- Config: CHIPS=1, DIV=1 → T=1+16+1=18. With HC595_OE_EN defined, oe_n=1 until cycle 18, then 0.

Source files
------------

// File: rtl/hc595_chain.sv
// ----------------------------------------------------------------------------
// hc595_chain
//
// Serial driver for a daisy-chain of CHIPS 74HC595 shift registers. A frame of
// 8*CHIPS bits is accepted through a valid/ready handshake. The frame is shifted
// out on ds/shcp (MSB-first or LSB-first), then latched into every chip with a
// single stcp pulse. Completion is reported with a one-cycle done pulse.
//
// Parameters
//   CHIPS     : number of chained 74HC595 devices (1..16), frame width W=8*CHIPS
//   DIV       : clk cycles per shcp phase (low or high), >= 1
//   MSB_FIRST : 1 shifts din[W-1] first, 0 shifts din[0] first
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   din      in   frame to shift out, sampled only on accept
//   din_vld  in   frame valid
//   din_rdy  out  high in IDLE; accept = din_vld && din_rdy
//   shcp     out  shift clock to the chain
//   stcp     out  storage-register latch clock to the chain
//   ds       out  serial data to the first chip
//   busy     out  high while shifting or latching (always ~din_rdy)
//   done     out  one-cycle pulse once a frame has been latched
//   oe_n     out  (only with HC595_OE_EN) /OE for the chain. It is held high
//                 after reset until the first frame has been latched, so
//                 power-up register garbage is never displayed.
//
// Build option: define HC595_OE_EN to add the oe_n port.
// ----------------------------------------------------------------------------
module hc595_chain #(
    parameter int CHIPS     = 2,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*CHIPS-1:0] din,
    input  logic               din_vld,
    output logic               din_rdy,
    output logic               shcp,
    output logic               stcp,
    output logic               ds,
    output logic               busy,
    output logic               done
`ifdef HC595_OE_EN
    ,
    output logic               oe_n
`endif
);

    localparam int W  = 8 * CHIPS;
    localparam int BW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          shcp_q, shcp_d;
    logic          stcp_q, stcp_d;
    logic          ds_q, ds_d;
    logic          done_q, done_d;
`ifdef HC595_OE_EN
    logic          oe_n_q, oe_n_d;
`endif

    // The shift register moves toward the output end, so the next bit to
    // present always sits at the same end of the shifted word.
    logic [W-1:0] sr_next;
    logic         next_bit;
    logic         phase_last;

    assign sr_next    = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    assign next_bit   = MSB_FIRST ? sr_next[W-1] : sr_next[0];
    assign phase_last = (phase_q == PH_LAST);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shcp_d  = shcp_q;
        stcp_d  = stcp_q;
        ds_d    = ds_q;
        done_d  = 1'b0;
`ifdef HC595_OE_EN
        oe_n_d  = oe_n_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // ds keeps the last shifted bit until the next accept.
                if (din_vld) begin
                    sr_d    = din;
                    ds_d    = MSB_FIRST ? din[W-1] : din[0];
                    bit_d   = '0;
                    phase_d = '0;
                    shcp_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (phase_last) begin
                    phase_d = '0;
                    if (!shcp_q) begin
                        shcp_d = 1'b1;
                    end else begin
                        // ds only moves on the falling shcp edge, so it is
                        // stable for the whole high phase the chip samples.
                        shcp_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            stcp_d  = 1'b1;
                            state_d = ST_LATCH;
                        end else begin
                            bit_d = bit_q + BW'(1);
                            sr_d  = sr_next;
                            ds_d  = next_bit;
                        end
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            ST_LATCH: begin
                if (phase_last) begin
                    phase_d = '0;
                    stcp_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef HC595_OE_EN
                    oe_n_d  = 1'b0;
`endif
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            ds_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef HC595_OE_EN
            oe_n_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            ds_q    <= ds_d;
            done_q  <= done_d;
`ifdef HC595_OE_EN
            oe_n_q  <= oe_n_d;
`endif
        end
    end

    assign din_rdy = (state_q == ST_IDLE);
    assign busy    = ~din_rdy;
    assign shcp    = shcp_q;
    assign stcp    = stcp_q;
    assign ds      = ds_q;
    assign done    = done_q;
`ifdef HC595_OE_EN
    assign oe_n    = oe_n_q;
`endif

endmodule
